// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array tile scheduler.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_NEXT,
      ST_FIN
   } sched_state_t;

   // A counter over a single slice still needs one bit to exist.
   function automatic int tile_w(input int slices);
      return (slices > 1) ? $clog2(slices) : 1;
   endfunction

   function automatic int k_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sched_popcnt.sv
// Combinational population count of the per-row result-valid flags.
module sched_popcnt #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  bits_i,
   output logic [CW-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < N; i++) begin
         count_o = count_o + CW'(bits_i[i]);
      end
   end

endmodule

// File: rtl/systolic_sched.sv
// Tile scheduler for an N1 x N2 systolic array computing an M x M multiply.
// Optional SYSTOLIC_SCHED_PERF_EN adds a saturating busy-cycle counter perf_cycles.
module systolic_sched
   import systolic_pkg::*;
#(
   parameter int D_W_ACC   = 16,
   parameter int N1        = 4,
   parameter int N2        = 4,
   parameter int M         = 8,
   parameter int DRAIN_MAX = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic                           enable_row_count_A,
   output logic                           init_pulse,
   output logic [tile_w(M/N1)-1:0]        tile_row,
   output logic [tile_w(M/N2)-1:0]        tile_col,
   output logic [k_w(M)-1:0]              k_cnt,
   input  logic [N1-1:0]                  valid_D,
   input  logic [N1-1:0][D_W_ACC-1:0]     D,
   output logic [N1-1:0]                  wr_en_C,
   output logic [N1-1:0][D_W_ACC-1:0]     wr_data_C
`ifdef SYSTOLIC_SCHED_PERF_EN
   ,
   output logic [31:0]                    perf_cycles
`endif
);

   localparam int TR_W    = tile_w(M/N1);
   localparam int TC_W    = tile_w(M/N2);
   localparam int K_W     = k_w(M);
   localparam int ROWS    = M / N1;
   localparam int COLS    = M / N2;
   localparam int RESULTS = N1 * N2;
   localparam int PC_W    = $clog2(N1 + 1);
   localparam int CNT_W   = $clog2(RESULTS + N1 + 1);
   localparam int DC_W    = $clog2(DRAIN_MAX + 1);

   sched_state_t           state_q, state_d;
   logic [TR_W-1:0]        tile_row_q, tile_row_d;
   logic [TC_W-1:0]        tile_col_q, tile_col_d;
   logic [K_W-1:0]         k_q, k_d;
   logic [CNT_W-1:0]       res_cnt_q, res_cnt_d;
   logic [DC_W-1:0]        drain_cnt_q, drain_cnt_d;
   logic                   error_q, error_d;
   logic [N1-1:0]          wr_en_q, wr_en_d;
   logic [N1-1:0][D_W_ACC-1:0] wr_data_q;

   logic [PC_W-1:0]        pop;
   logic [CNT_W-1:0]       cnt_sum;
   logic                   last_k;
   logic                   last_tile;

   sched_popcnt #(
      .N  (N1),
      .CW (PC_W)
   ) u_popcnt (
      .bits_i  (valid_D),
      .count_o (pop)
   );

   assign cnt_sum   = res_cnt_q + CNT_W'(pop);
   assign last_k    = (k_q == K_W'(M - 1));
   assign last_tile = (tile_row_q == TR_W'(ROWS - 1)) && (tile_col_q == TC_W'(COLS - 1));

   // Results are only accepted for the tile currently draining.
   assign wr_en_d = (state_q == ST_DRAIN) ? valid_D : '0;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d            = state_q;
      tile_row_d         = tile_row_q;
      tile_col_d         = tile_col_q;
      k_d                = k_q;
      res_cnt_d          = res_cnt_q;
      drain_cnt_d        = drain_cnt_q;
      error_d            = error_q;
      busy               = 1'b1;
      done               = 1'b0;
      enable_row_count_A = 1'b0;
      init_pulse         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d    = ST_FEED;
               tile_row_d = '0;
               tile_col_d = '0;
               k_d        = '0;
               error_d    = 1'b0;
            end
         end
         ST_FEED: begin
            enable_row_count_A = 1'b1;
            if (last_k) begin
               init_pulse  = 1'b1;
               k_d         = '0;
               res_cnt_d   = '0;
               drain_cnt_d = '0;
               state_d     = ST_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            res_cnt_d   = cnt_sum;
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (cnt_sum >= CNT_W'(RESULTS)) begin
               state_d = ST_NEXT;
            end else if (drain_cnt_q == DC_W'(DRAIN_MAX - 1)) begin
               error_d = 1'b1;
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // The final tile keeps its indices so they remain visible after done.
            if (last_tile) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_FEED;
               k_d     = '0;
               if (tile_col_q == TC_W'(COLS - 1)) begin
                  tile_col_d = '0;
                  tile_row_d = tile_row_q + 1'b1;
               end else begin
                  tile_col_d = tile_col_q + 1'b1;
               end
            end
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tile_row_q  <= '0;
         tile_col_q  <= '0;
         k_q         <= '0;
         res_cnt_q   <= '0;
         drain_cnt_q <= '0;
         error_q     <= 1'b0;
         wr_en_q     <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         tile_row_q  <= tile_row_d;
         tile_col_q  <= tile_col_d;
         k_q         <= k_d;
         res_cnt_q   <= res_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         error_q     <= error_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= D;
      end
   end

   assign tile_row  = tile_row_q;
   assign tile_col  = tile_col_q;
   assign k_cnt     = k_q;
   assign error     = error_q;
   assign wr_en_C   = wr_en_q;
   assign wr_data_C = wr_data_q;

`ifdef SYSTOLIC_SCHED_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         perf_q <= '0;
      end else if (busy && (perf_q != '1)) begin
         perf_q <= perf_q + 1'b1;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched: table of tiles across three runs plus reset/start corners.
module tb_systolic_sched;

   localparam int D_W_ACC   = 16;
   localparam int N1        = 4;
   localparam int N2        = 4;
   localparam int M         = 8;
   localparam int DRAIN_MAX = 64;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       start;
   logic                       busy, done, error, enable_row_count_A, init_pulse;
   logic [0:0]                 tile_row, tile_col;
   logic [2:0]                 k_cnt;
   logic [N1-1:0]              valid_D;
   logic [N1-1:0][D_W_ACC-1:0] D;
   logic [N1-1:0]              wr_en_C;
   logic [N1-1:0][D_W_ACC-1:0] wr_data_C;
`ifdef SYSTOLIC_SCHED_PERF_EN
   logic [31:0]                perf_cycles;
`endif

   systolic_sched #(
      .D_W_ACC   (D_W_ACC),
      .N1        (N1),
      .N2        (N2),
      .M         (M),
      .DRAIN_MAX (DRAIN_MAX)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .error              (error),
      .enable_row_count_A (enable_row_count_A),
      .init_pulse         (init_pulse),
      .tile_row           (tile_row),
      .tile_col           (tile_col),
      .k_cnt              (k_cnt),
      .valid_D            (valid_D),
      .D                  (D),
      .wr_en_C            (wr_en_C),
      .wr_data_C          (wr_data_C)
`ifdef SYSTOLIC_SCHED_PERF_EN
      ,
      .perf_cycles        (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit first;
      bit last;
      int row;
      int col;
      bit withhold;
      int abort_k;
      int drain_len;
      bit err_after;
      bit mid_start;
   } tile_vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int busy_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_seen++;
   endtask

   // Staggered arrival: 1,2,3,4,3,2,1 results per cycle = 16 per tile.
   function automatic logic [N1-1:0] pattern(input int j, input bit withhold);
      case (j)
         0: return 4'b0001;
         1: return 4'b0011;
         2: return 4'b0111;
         3: return 4'b1111;
         4: return 4'b1110;
         5: return 4'b1100;
         6: return withhold ? 4'b0000 : 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [N1-1:0][D_W_ACC-1:0] data_for(input int t, input int j);
      logic [N1-1:0][D_W_ACC-1:0] d;
      for (int r = 0; r < N1; r++) d[r] = 16'(t * 256 + j * 16 + r);
      return d;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_en"},    enable_row_count_A, 0);
      check({tag, "_init"},  init_pulse, 0);
      check({tag, "_row"},   tile_row, 0);
      check({tag, "_col"},   tile_col, 0);
      check({tag, "_k"},     k_cnt, 0);
      check({tag, "_wren"},  wr_en_C, 0);
      check({tag, "_wrdat"}, wr_data_C, 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
      check({tag, "_perf"},  perf_cycles, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tile_vec_t tv[10];
      tile_vec_t v;
      logic [N1-1:0] prev_v;
      logic [N1-1:0][D_W_ACC-1:0] prev_d;
      int exp_busy;
      int wr_bits;
      bit aborted;

      //         first last row col whold abort drain err  mid
      tv[0] = '{1, 0, 0, 0, 0, -1,  7, 0, 0};
      tv[1] = '{0, 0, 0, 1, 0, -1,  7, 0, 0};
      tv[2] = '{0, 0, 1, 0, 0, -1,  7, 0, 0};
      tv[3] = '{0, 1, 1, 1, 0, -1,  7, 0, 0};
      tv[4] = '{1, 0, 0, 0, 0, -1,  7, 0, 0};
      tv[5] = '{0, 0, 0, 1, 0, -1,  7, 0, 1};
      tv[6] = '{0, 0, 1, 0, 1, -1, 64, 1, 0};
      tv[7] = '{0, 1, 1, 1, 0, -1,  7, 1, 0};
      tv[8] = '{1, 0, 0, 0, 0, -1,  7, 0, 0};
      tv[9] = '{0, 0, 0, 1, 0,  5,  7, 0, 0};

      rst = 1'b1; start = 1'b0; valid_D = '0; D = '0;
      step(); step();
      rst = 1'b0;
      check_all_zero("reset");
      step();
      check("idle_busy", busy, 0);

      exp_busy = 0;
      prev_v   = '0;
      prev_d   = '0;

      for (int i = 0; i < 10; i++) begin
         v = tv[i];
         aborted = 1'b0;
         if (v.first) begin
            start = 1'b1; busy_seen = 0; exp_busy = 0;
            step();
            start = 1'b0;
            check("start_err_clr", error, 0);
         end

         for (int k = 0; k < M; k++) begin
            check("feed_busy", busy, 1);
            check("feed_en",   enable_row_count_A, 1);
            check("feed_k",    k_cnt, k);
            check("feed_init", init_pulse, (k == M - 1));
            check("feed_row",  tile_row, v.row);
            check("feed_col",  tile_col, v.col);
            check("feed_done", done, 0);
            check("feed_wren", wr_en_C, 0);
            start = (v.mid_start && k == 3);
            if (v.abort_k == k) begin
               rst = 1'b1;
               step();
               rst = 1'b0; start = 1'b0;
               valid_D = '1; D = data_for(9, 0);
               check_all_zero("abort");
               step();
               check("abort_nowrite", wr_en_C, 0);
               check("abort_idle", busy, 0);
               valid_D = '0;
               aborted = 1'b1;
               break;
            end
            step();
         end
         if (aborted) continue;
         start = 1'b0;
         exp_busy += M + v.drain_len + 1;

         wr_bits = 0;
         prev_v  = '0;
         for (int j = 0; j < v.drain_len; j++) begin
            check("drain_busy", busy, 1);
            check("drain_en",   enable_row_count_A, 0);
            check("drain_init", init_pulse, 0);
            check("drain_done", done, 0);
            check("drain_wren", wr_en_C, prev_v);
            if (prev_v != '0) check("drain_wrdat", wr_data_C, prev_d);
            wr_bits += $countones(wr_en_C);
            valid_D = pattern(j, v.withhold);
            D       = data_for(i, j);
            prev_v  = valid_D;
            prev_d  = D;
            step();
         end

         check("next_busy",  busy, 1);
         check("next_en",    enable_row_count_A, 0);
         check("next_done",  done, 0);
         check("next_wren",  wr_en_C, prev_v);
         if (prev_v != '0) check("next_wrdat", wr_data_C, prev_d);
         check("next_error", error, v.err_after);
         wr_bits += $countones(wr_en_C);
         check("tile_results", wr_bits, v.withhold ? 15 : 16);
         valid_D = '1; D = data_for(15, 15);
         step();
         valid_D = '0;

         if (v.last) begin
            check("fin_done", done, 1);
            check("fin_busy", busy, 1);
            check("fin_en",   enable_row_count_A, 0);
            check("fin_row",  tile_row, v.row);
            check("fin_col",  tile_col, v.col);
            check("fin_wren", wr_en_C, 0);
            start = 1'b1;
            exp_busy += 1;
            step();
            start = 1'b0;
            check("end_busy",  busy, 0);
            check("end_done",  done, 0);
            check("end_row",   tile_row, v.row);
            check("end_col",   tile_col, v.col);
            check("end_error", error, v.err_after);
            check("busy_cycles", busy_seen, exp_busy);
`ifdef SYSTOLIC_SCHED_PERF_EN
            check("perf_end", perf_cycles, exp_busy);
`endif
            step(); step();
            check("idle_busy_hold",  busy, 0);
            check("idle_error_hold", error, v.err_after);
`ifdef SYSTOLIC_SCHED_PERF_EN
            check("perf_hold", perf_cycles, exp_busy);
`endif
         end
      end

      step();
      check("final_idle", busy, 0);
      check("final_wren", wr_en_C, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/systolic_sched.md
SYSTOLIC_SCHED -- requirements
Module: systolic_sched

Interface
REQ-001 Parameter D_W_ACC, default 16: accumulator result width, matching the array's D outputs.
REQ-002 Parameter N1, default 4: array rows.
REQ-003 Parameter N2, default 4: array columns.
REQ-004 Parameter M, default 8: square matrix dimension; M divisible by N1 and by N2.
REQ-005 Parameter DRAIN_MAX, default 64: maximum number of DRAIN cycles before timeout.
REQ-006 clk  in  1  single clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  request a full M x M multiply; sampled only in IDLE.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when all tiles have completed.
REQ-011 error  out  1  sticky drain-timeout flag; cleared by rst or by an accepted start.
REQ-012 enable_row_count_A  out  1  drives the array's A-side operand counter.
REQ-013 init_pulse  out  1  one-cycle pulse marking the last operand beat of a tile.
REQ-014 tile_row  out  max(clog2(M/N1),1)  current row-slice index.
REQ-015 tile_col  out  max(clog2(M/N2),1)  current column-slice index.
REQ-016 k_cnt  out  clog2(M)  current operand beat within FEED.
REQ-017 valid_D  in  N1  per-row result-valid flags from the array.
REQ-018 D  in  N1 x D_W_ACC  result data; passes through to wr_data_C.
REQ-019 wr_en_C  out  N1  registered copy of valid_D, masked to zero outside DRAIN.
REQ-020 wr_data_C  out  N1 x D_W_ACC  D registered alongside wr_en_C.

Function
REQ-021 FSM states: IDLE, FEED, DRAIN, NEXT, FIN.
REQ-022 IDLE -> FEED when start=1; on that edge tile_row=0, tile_col=0, k_cnt=0 and error is cleared.
REQ-023 FEED lasts exactly M cycles, with enable_row_count_A=1 and k_cnt stepping 0..M-1.
REQ-024 init_pulse=1 only in the FEED cycle where k_cnt==M-1; after that cycle the FSM enters DRAIN.
REQ-025 DRAIN counts results: each cycle the result count increases by popcount(valid_D), and the counter is cleared on DRAIN entry.
REQ-026 When the result count reaches N1*N2, DRAIN -> NEXT.
REQ-027 If the result count is still below N1*N2 after DRAIN_MAX cycles, error is set and the FSM goes DRAIN -> NEXT.
REQ-028 NEXT is a single cycle; tile_col increments first, and when it wraps to 0, tile_row increments.
REQ-029 From NEXT the FSM enters FIN if the finished tile was the last one (tile_row=M/N1-1 and tile_col=M/N2-1); otherwise it enters FEED with k_cnt=0.
REQ-030 FIN lasts one cycle with done=1, then returns to IDLE; tile_row and tile_col hold their last values.
REQ-031 start is ignored while busy=1.
REQ-032 Result writes have 1-cycle latency: wr_en_C and wr_data_C in cycle t+1 reflect valid_D and D from cycle t.
REQ-033 Results that arrive exactly on the cycle the count reaches N1*N2 are still written.

Reset
REQ-034 On rst=1 at a clock edge, the FSM enters IDLE from any state, including mid-FEED and mid-DRAIN.
REQ-035 Reset values: all counters and all outputs are 0, including error and wr_en_C.
REQ-036 A result arriving in the cycle after reset is not written.

Configuration
REQ-037 With SYSTOLIC_SCHED_PERF_EN defined, the block adds a 32-bit output perf_cycles: cleared on an accepted start, incremented each cycle while busy, held in IDLE, saturating at all-ones.
REQ-038 Without SYSTOLIC_SCHED_PERF_EN, the perf_cycles port and its logic are absent.

Structure
REQ-039 A shared package systolic_pkg holds the FSM state enum sched_state_t and the width helpers for the tile and k counters.
REQ-040 A single sub-module, sched_popcnt, computes popcount of valid_D in combinational logic.

Verification
REQ-041 Nominal run (N1=N2=4, M=8): start pulse -> 4 tiles in order (0,0),(0,1),(1,0),(1,1); each tile has 8 FEED cycles and one init_pulse; done pulses once; error=0.
REQ-042 Results model returns 16 valid beats per tile, staggered -> 16 wr_en_C bits per tile, each one cycle after its valid_D, with matching data.
REQ-043 Model withholds one result in tile 2 -> DRAIN times out after exactly 64 cycles; error=1 and stays 1; run still completes with done.
REQ-044 start asserted mid-run -> no effect; a following start in IDLE clears error and restarts at tile (0,0).
REQ-045 rst asserted at k_cnt=5 of tile 1 -> next cycle state is IDLE and all outputs are 0; a valid_D pulse in the following cycle produces no write.
REQ-046 Build with SYSTOLIC_SCHED_PERF_EN and run the nominal case -> perf_cycles equals the number of busy cycles counted by the bench.
